// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier: flush-to-zero inputs, six rounding modes, IEEE-style exception flags.
// Latency is 3 cycles at 1 result/cycle; a held output (out_valid && !out_ready) freezes every stage.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [2:0]           rnd,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] z,
  output logic [7:0]           status,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 2);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1: unpack and classify
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign fa     = a[MAN_W-1:0];
  assign fb     = b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [EW-1:0] s1_exp;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic [2:0]           s1_rnd;
  logic [TAG_W-1:0]     s1_tag;

  // S2: mantissa product and normalise to 1.x with guard/sticky
  logic [PW-1:0] prod;
  logic          prod_hi;
  assign prod    = PW'(s1_ma) * PW'(s1_mb);
  assign prod_hi = prod[PW-1];

  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero, s2_guard, s2_sticky;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W:0]       s2_mant;
  logic [2:0]           s2_rnd;
  logic [TAG_W-1:0]     s2_tag;

  // S3: round, renormalise on carry-out, then resolve exceptions
  logic                 inc, toward_sign, carry, ovf_inf, unf_min;
  logic [MAN_W+1:0]     rounded;
  logic signed [EW-1:0] exp_f;
  logic [MAN_W-1:0]     frac_f;
  logic [W-1:0]         res_z;
  logic                 f_inexact, f_huge, f_tiny, f_nan, f_inf, f_zero;

  always_comb begin
    toward_sign = (s2_rnd == 3'b010 && !s2_sign) || (s2_rnd == 3'b011 && s2_sign);
    case (s2_rnd)
      3'b001:         inc = 1'b0;
      3'b010, 3'b011: inc = toward_sign && (s2_guard || s2_sticky);
      3'b100:         inc = s2_guard;
      3'b101:         inc = s2_guard || s2_sticky;
      default:        inc = s2_guard && (s2_sticky || s2_mant[0]);
    endcase
    ovf_inf = (s2_rnd == 3'b010 || s2_rnd == 3'b011) ? toward_sign : (s2_rnd != 3'b001);
    unf_min = (s2_rnd == 3'b101) || toward_sign;
  end

  assign rounded = {1'b0, s2_mant} + {{(MAN_W + 1){1'b0}}, inc};
  assign carry   = rounded[MAN_W+1];
  assign exp_f   = s2_exp + {{(EW - 1){1'b0}}, carry};
  assign frac_f  = carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

  always_comb begin
    res_z     = '0;
    f_inexact = 1'b0;
    f_huge    = 1'b0;
    f_tiny    = 1'b0;
    f_nan     = 1'b0;
    f_inf     = 1'b0;
    f_zero    = 1'b0;
    if (s2_nan) begin
      res_z = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
      f_nan = 1'b1;
    end else if (s2_inf) begin
      res_z = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f_inf = 1'b1;
    end else if (s2_zero) begin
      res_z  = {s2_sign, {(W - 1){1'b0}}};
      f_zero = 1'b1;
    end else if (exp_f > EXP_MAX) begin
      f_huge    = 1'b1;
      f_inexact = 1'b1;
      f_inf     = ovf_inf;
      res_z     = ovf_inf ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {s2_sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else if (exp_f < EXP_ONE) begin
      f_tiny    = 1'b1;
      f_inexact = 1'b1;
      f_zero    = !unf_min;
      res_z     = unf_min ? {s2_sign, {(EXP_W - 1){1'b0}}, 1'b1, {MAN_W{1'b0}}}
                          : {s2_sign, {(W - 1){1'b0}}};
    end else begin
      res_z     = {s2_sign, exp_f[EXP_W-1:0], frac_f};
      f_inexact = s2_guard || s2_sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      z         <= '0;
      status    <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        z       <= res_z;
        status  <= {2'b00, f_inexact, f_huge, f_tiny, f_nan, f_inf, f_zero};
        out_tag <= s2_tag;
      end
    end
  end

  // Datapath registers need no reset: their valids gate everything downstream
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign   <= a[W-1] ^ b[W-1];
      s1_nan    <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
      s1_inf    <= a_inf || b_inf;
      s1_zero   <= a_zero || b_zero;
      s1_exp    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      s1_ma     <= {1'b1, fa};
      s1_mb     <= {1'b1, fb};
      s1_rnd    <= rnd;
      s1_tag    <= in_tag;
      s2_sign   <= s1_sign;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_exp    <= s1_exp + {{(EW - 1){1'b0}}, prod_hi};
      s2_mant   <= prod_hi ? prod[PW-1:MAN_W+1] : prod[PW-2:MAN_W];
      s2_guard  <= prod_hi ? prod[MAN_W] : prod[MAN_W-1];
      s2_sticky <= prod_hi ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
      s2_rnd    <= s1_rnd;
      s2_tag    <= s1_tag;
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe on single- and double-precision instances: directed corners, stall and
// reset scenarios, and a randomized stream scored against an exact-integer reference multiplier.
`timescale 1ns/1ps
module tb_fp_mult_pipe;
  typedef struct packed {
    logic [63:0] z;
    logic [7:0]  st;
    logic [3:0]  tag;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv0, ir0, ov0, or0;
  logic [31:0] a0, b0, z0;
  logic [2:0]  rnd0;
  logic [3:0]  it0, ot0;
  logic [7:0]  st0;
  logic        iv1, ir1, ov1, or1;
  logic [63:0] a1, b1, z1;
  logic [2:0]  rnd1;
  logic [3:0]  it1, ot1;
  logic [7:0]  st1;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut_sp (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .rnd(rnd0),
    .in_tag(it0), .out_valid(ov0), .out_ready(or0), .z(z0), .status(st0), .out_tag(ot0));

  fp_mult_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(4)) dut_dp (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .rnd(rnd1),
    .in_tag(it1), .out_valid(ov1), .out_ready(or1), .z(z1), .status(st1), .out_tag(ot1));

  int   total = 0;
  int   bad = 0;
  res_t exp_q0[$];
  res_t exp_q1[$];

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: exact integer product, rounding decided by comparing the discarded remainder with a half ulp
  function automatic res_t fp_ref(int ew, int mw, logic [63:0] a, logic [63:0] b,
                                  logic [2:0] rnd, logic [3:0] tag);
    res_t r;
    int emax, bias, ea, eb, e, sh;
    logic [63:0] fmask, fa, fb, sgn, inf_pat;
    logic [127:0] prod, kept, rem, half;
    logic sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, hi, exact, up, dir, big;
    emax  = (1 << ew) - 1;
    bias  = (1 << (ew - 1)) - 1;
    fmask = (64'd1 << mw) - 64'd1;
    ea    = int'((a >> mw) & 64'(emax));
    eb    = int'((b >> mw) & 64'(emax));
    fa    = a & fmask;
    fb    = b & fmask;
    sign  = a[ew+mw] ^ b[ew+mw];
    sgn   = {63'd0, sign} << (ew + mw);
    inf_pat = sgn | (64'(emax) << mw);
    a_nan = (ea == emax) && (fa != 0);
    b_nan = (eb == emax) && (fb != 0);
    a_inf = (ea == emax) && (fa == 0);
    b_inf = (eb == emax) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    r.tag = tag;
    dir = (rnd == 3'd2 && !sign) || (rnd == 3'd3 && sign);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r.z  = (64'(emax) << mw) | (64'd1 << (mw - 1));
      r.st = 8'h04;
    end else if (a_inf || b_inf) begin
      r.z  = inf_pat;
      r.st = 8'h02;
    end else if (a_zero || b_zero) begin
      r.z  = sgn;
      r.st = 8'h01;
    end else begin
      prod  = 128'(fa | (64'd1 << mw)) * 128'(fb | (64'd1 << mw));
      hi    = prod >= (128'd1 << (2 * mw + 1));
      sh    = mw + (hi ? 1 : 0);
      e     = ea + eb - bias + (hi ? 1 : 0);
      kept  = prod >> sh;
      rem   = prod - (kept << sh);
      half  = 128'd1 << (sh - 1);
      exact = (rem == 0);
      case (rnd)
        3'd1:       up = 1'b0;
        3'd2, 3'd3: up = dir && !exact;
        3'd4:       up = rem >= half;
        3'd5:       up = !exact;
        default:    up = (rem > half) || (rem == half && kept[0]);
      endcase
      kept = kept + 128'(up);
      if (kept == (128'd1 << (mw + 1))) begin
        kept = kept >> 1;
        e++;
      end
      if (e > emax - 1) begin
        big  = (rnd == 3'd2 || rnd == 3'd3) ? dir : (rnd != 3'd1);
        r.z  = big ? inf_pat : (sgn | (64'(emax - 1) << mw) | fmask);
        r.st = big ? 8'h32 : 8'h30;
      end else if (e < 1) begin
        big  = (rnd == 3'd5) || dir;
        r.z  = big ? (sgn | (64'd1 << mw)) : sgn;
        r.st = big ? 8'h28 : 8'h29;
      end else begin
        r.z  = sgn | (64'(e) << mw) | (kept[63:0] & fmask);
        r.st = exact ? 8'h00 : 8'h20;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] gen_op(int ew, int mw);
    logic [63:0] fr, ex, sg;
    int emax, k;
    emax = (1 << ew) - 1;
    k    = int'($urandom_range(0, 15));
    fr   = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    ex   = 64'($urandom_range(1, emax - 1));
    sg   = 64'($urandom_range(0, 1));
    case (k)
      0: ex = 64'd0;
      1: begin ex = 64'(emax); fr = 64'd0; end
      2: ex = 64'(emax);
      3: ex = 64'd1;
      4: ex = 64'(emax - 1);
      5: fr = (64'd1 << mw) - 64'd1;
      6: fr = fr & ~((64'd1 << (mw - 3)) - 64'd1);
      7: fr = 64'd0;
      default: ;
    endcase
    return (sg << (ew + mw)) | (ex << mw) | fr;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (rst) exp_q0.delete();
    else begin
      if (iv0 && ir0) exp_q0.push_back(fp_ref(8, 23, {32'd0, a0}, {32'd0, b0}, rnd0, it0));
      if (ov0 && or0) begin
        if (exp_q0.size() == 0) check("sp_unexpected_out", 64'(ov0), 64'd0);
        else begin
          e = exp_q0.pop_front();
          check("sp_z", {32'd0, z0}, e.z);
          check("sp_status", 64'(st0), 64'(e.st));
          check("sp_tag", 64'(ot0), 64'(e.tag));
        end
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst) exp_q1.delete();
    else begin
      if (iv1 && ir1) exp_q1.push_back(fp_ref(11, 52, a1, b1, rnd1, it1));
      if (ov1 && or1) begin
        if (exp_q1.size() == 0) check("dp_unexpected_out", 64'(ov1), 64'd0);
        else begin
          e = exp_q1.pop_front();
          check("dp_z", z1, e.z);
          check("dp_status", 64'(st1), 64'(e.st));
          check("dp_tag", 64'(ot1), 64'(e.tag));
        end
      end
    end
  end

  task automatic drive(int sel, logic v, logic [63:0] a, logic [63:0] b, logic [2:0] r, logic [3:0] t);
    if (sel == 0) begin iv0 = v; a0 = a[31:0]; b0 = b[31:0]; rnd0 = r; it0 = t; end
    else begin iv1 = v; a1 = a; b1 = b; rnd1 = r; it1 = t; end
  endtask

  task automatic set_ordy(int sel, logic r);
    if (sel == 0) or0 = r; else or1 = r;
  endtask

  function automatic logic in_acc(int sel);
    return (sel == 0) ? (iv0 && ir0) : (iv1 && ir1);
  endfunction
  function automatic logic get_iv(int sel);  return (sel == 0) ? iv0 : iv1; endfunction
  function automatic logic get_ir(int sel);  return (sel == 0) ? ir0 : ir1; endfunction
  function automatic logic get_ov(int sel);  return (sel == 0) ? ov0 : ov1; endfunction
  function automatic logic [63:0] get_z(int sel); return (sel == 0) ? {32'd0, z0} : z1; endfunction
  function automatic logic [7:0] get_st(int sel); return (sel == 0) ? st0 : st1; endfunction
  function automatic logic [3:0] get_tag(int sel); return (sel == 0) ? ot0 : ot1; endfunction
  function automatic int qsize(int sel); return (sel == 0) ? exp_q0.size() : exp_q1.size(); endfunction

  task automatic drain(int sel, string name);
    int w = 0;
    set_ordy(sel, 1'b1);
    while (qsize(sel) != 0 && w < 40) begin @(posedge clk); w++; end
    @(posedge clk); #1;
    check({name, "_drain"}, 64'(qsize(sel)), 64'd0);
  endtask

  // One op into an empty pipe; checks the exact 3-cycle latency and the result
  task automatic single_op(int sel, string name, logic [63:0] a, logic [63:0] b, logic [2:0] r,
                           logic [3:0] t, logic [63:0] ez, logic [7:0] est);
    int waited = 0;
    @(posedge clk); #1;
    drive(sel, 1'b1, a, b, r, t);
    @(negedge clk);
    while (!in_acc(sel) && waited < 10) begin @(negedge clk); waited++; end
    check({name, "_accept"}, 64'(in_acc(sel)), 64'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 64'd0, 64'd0, 3'd0, 4'd0);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c < 3) check({name, "_early_valid"}, 64'(get_ov(sel)), 64'd0);
    end
    check({name, "_valid"}, 64'(get_ov(sel)), 64'd1);
    check({name, "_z"}, get_z(sel), ez);
    check({name, "_status"}, 64'(get_st(sel)), 64'(est));
    check({name, "_tag"}, 64'(get_tag(sel)), 64'(t));
  endtask

  task automatic stall_test(int sel);
    int n = 0;
    int ew = (sel != 0) ? 11 : 8;
    int mw = (sel != 0) ? 52 : 23;
    logic acc;
    logic [63:0] held_z = 64'd0;
    set_ordy(sel, 1'b0);
    @(posedge clk); #1;
    drive(sel, 1'b1, gen_op(ew, mw), gen_op(ew, mw), 3'd0, 4'd1);
    for (int c = 0; c < 24 && n < 4; c++) begin
      @(negedge clk); acc = in_acc(sel);
      @(posedge clk); #1;
      if (acc) begin
        n++;
        if (n < 4) drive(sel, 1'b1, gen_op(ew, mw), gen_op(ew, mw), 3'(n), 4'(n + 1));
        else drive(sel, 1'b0, 64'd0, 64'd0, 3'd0, 4'd0);
      end
      if (c == 3) held_z = get_z(sel);
      if (c == 6) begin
        check("stall_accepts", 64'(n), 64'd3);
        check("stall_in_ready", 64'(get_ir(sel)), 64'd0);
        check("stall_out_valid", 64'(get_ov(sel)), 64'd1);
        check("stall_hold_z", get_z(sel), held_z);
        set_ordy(sel, 1'b1);
      end
    end
    check("stall_all_accepted", 64'(n), 64'd4);
    drain(sel, "stall");
  endtask

  task automatic run_random(int sel, int nops, string name);
    int sent = 0;
    int cyc = 0;
    int ew = (sel != 0) ? 11 : 8;
    int mw = (sel != 0) ? 52 : 23;
    logic acc;
    @(posedge clk); #1;
    drive(sel, 1'b1, gen_op(ew, mw), gen_op(ew, mw), 3'($urandom_range(0, 7)), 4'($urandom));
    while (sent < nops && cyc < 20 * nops) begin
      @(negedge clk); acc = in_acc(sel);
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      if (acc || !get_iv(sel))
        drive(sel, (sent < nops) && ($urandom_range(0, 4) != 0), gen_op(ew, mw), gen_op(ew, mw),
              3'($urandom_range(0, 7)), 4'($urandom));
      set_ordy(sel, $urandom_range(0, 3) != 0);
    end
    drive(sel, 1'b0, 64'd0, 64'd0, 3'd0, 4'd0);
    check({name, "_sent"}, 64'(sent), 64'(nops));
    drain(sel, name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 64'd0, 64'd0, 3'd0, 4'd0);
    drive(1, 1'b0, 64'd0, 64'd0, 3'd0, 4'd0);
    or0 = 1'b1;
    or1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sp_valid", 64'(ov0), 64'd0);
    check("rst_sp_z", {32'd0, z0}, 64'd0);
    check("rst_sp_status", 64'(st0), 64'd0);
    check("rst_sp_tag", 64'(ot0), 64'd0);
    check("rst_dp_valid", 64'(ov1), 64'd0);
    check("rst_dp_z", z1, 64'd0);
    rst = 1'b0;
    check("rst_in_ready", 64'(ir0), 64'd1);

    single_op(0, "mul_3x2", 64'h40400000, 64'h40000000, 3'd0, 4'd5, 64'h40C00000, 8'h00);
    single_op(0, "ovf_rne", 64'h7F000000, 64'h7F000000, 3'd0, 4'd1, 64'h7F800000, 8'h32);
    single_op(0, "ovf_rz", 64'h7F000000, 64'h7F000000, 3'd1, 4'd2, 64'h7F7FFFFF, 8'h30);
    single_op(0, "inf_x_0", 64'h7F800000, 64'h00000000, 3'd0, 4'd3, 64'h7FC00000, 8'h04);
    single_op(0, "unf_rne", 64'h00800000, 64'h00800000, 3'd0, 4'd4, 64'h00000000, 8'h29);
    single_op(0, "unf_away", 64'h00800000, 64'h00800000, 3'd5, 4'd6, 64'h00800000, 8'h28);
    single_op(0, "unf_neg_rm", 64'h80800000, 64'h00800000, 3'd3, 4'd7, 64'h80800000, 8'h28);
    single_op(0, "neg_mul", 64'hC0400000, 64'h40000000, 3'd0, 4'd8, 64'hC0C00000, 8'h00);
    single_op(0, "neg_zero", 64'h80000000, 64'h3F800000, 3'd0, 4'd9, 64'h80000000, 8'h01);
    single_op(0, "neg_inf", 64'hFF800000, 64'h40000000, 3'd0, 4'd10, 64'hFF800000, 8'h02);
    single_op(0, "rnd_rne", 64'h3F800001, 64'h3F800001, 3'd0, 4'd11, 64'h3F800002, 8'h20);
    single_op(0, "rnd_rp", 64'h3F800001, 64'h3F800001, 3'd2, 4'd12, 64'h3F800003, 8'h20);
    single_op(1, "dp_mul", 64'h4008000000000000, 64'h4000000000000000, 3'd0, 4'd13,
              64'h4018000000000000, 8'h00);
    single_op(1, "dp_ovf_rz", 64'h7FE0000000000000, 64'h7FE0000000000000, 3'd1, 4'd14,
              64'h7FEFFFFFFFFFFFFF, 8'h30);

    stall_test(0);

    // Two ops in flight, then a one-cycle reset: nothing may emerge afterwards
    @(posedge clk); #1;
    drive(0, 1'b1, 64'h40400000, 64'h40000000, 3'd0, 4'd1);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'h40000000, 64'h40000000, 3'd0, 4'd2);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 64'd0, 3'd0, 4'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("inflight_rst_valid", 64'(ov0), 64'd0);
    check("inflight_rst_in_ready", 64'(ir0), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("inflight_no_stale", 64'(ov0), 64'd0);
    end
    single_op(0, "post_rst", 64'h40400000, 64'h40000000, 3'd0, 4'd5, 64'h40C00000, 8'h00);

    run_random(0, 1500, "sp_rand");
    run_random(1, 1500, "dp_rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
